handshake_constant_table: RTL and testbench
===========================================

Name: handshake_constant_table

Overview:
- Parametrised successor to the single-value dataflow constant source.
- Emits a sequence of compile-time constants from a table, one value per control token.
- Registered output stage, so the constant path is cut from the control path.
- Sits between a control-token producer and a data consumer in the elastic handshake fabric.

Parameters:
- DATA_WIDTH, 32, width of each constant and of outs.
- NUM_CONSTS, 4, number of table entries (>=1).
- CONST_TABLE, all zeros, flattened table of NUM_CONSTS*DATA_WIDTH bits; entry k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
- WRAP, 1, 1 = index wraps to 0 after the last entry; 0 = index saturates at the last entry.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous reset, active-low (0 = reset).
- restart  input  1  synchronous request to return the sequence index to 0.
- ctrl_valid  input  1  control token valid.
- ctrl_ready  output  1  control token accepted.
- outs  output  DATA_WIDTH  constant value held in the output register.
- outs_valid  output  1  output register holds a token.
- outs_ready  input  1  consumer ready.
- outs_last  output  1  the token in outs came from entry NUM_CONSTS-1.
- outs_idx  output  IW  table index of the token in outs; IW = max(1, clog2(NUM_CONSTS)).

Behaviour:
- Reset (rst=0 at an edge):
  - outs_valid=0, outs=0, outs_last=0, outs_idx=0; internal index idx=0.
  - Reset dominates every other input that cycle.
  - Reset mid-stream drops any held token; no partial state survives.
- Handshakes:
  - Accept: ctrl_fire = ctrl_valid & ctrl_ready.
  - Emit: outs_fire = outs_valid & outs_ready.
  - ctrl_ready = ~outs_valid | outs_ready (combinational; one-slot pipeline with full throughput).
  - No combinational path from ctrl_valid to outs or outs_valid.
- Latency: 1 cycle from ctrl_fire to outs_valid=1.
- Sustained throughput: 1 token/cycle while outs_ready=1.
- Output register update:
  - On ctrl_fire: outs <= table[e], outs_idx <= e, outs_last <= (e==NUM_CONSTS-1), outs_valid <= 1.
  - Else if outs_fire: outs_valid <= 0. outs, outs_idx and outs_last hold their last values.
  - Else: all outputs hold. A stalled token keeps outs stable until consumed.
- Entry selection: e = restart ? 0 : idx.
- Index update, on ctrl_fire only:
  - Next index n = e+1 when e < NUM_CONSTS-1.
  - When e == NUM_CONSTS-1: n = 0 if WRAP=1, n = NUM_CONSTS-1 if WRAP=0.
  - idx <= n.
- restart without ctrl_fire: idx <= 0, and the next accepted token uses entry 0.
- restart with ctrl_fire in the same cycle: the accepted token uses entry 0, and idx <= 1 (or 0 if NUM_CONSTS==1).
- NUM_CONSTS==1:
  - idx is constant 0; outs_last=1 on every emitted token.
  - This case behaves as the original constant source plus one register stage.
- Simultaneous ctrl_fire and outs_fire: the old token leaves, the new token is loaded, outs_valid stays 1.
- Index arithmetic is IW bits wide. The NUM_CONSTS-1 compare is exact, so a non-power-of-two table never indexes past the last entry.

Test Plan:
- Common setup: DATA_WIDTH=8, NUM_CONSTS=3, CONST_TABLE={0x33,0x22,0x11} (entry0=0x11), WRAP=1.
- Reset: hold rst=0 for 3 cycles with ctrl_valid=1 -> outs_valid=0, outs=0x00, outs_idx=0, outs_last=0. Release rst -> the first token appears on the next cycle with outs=0x11.
- Streaming: ctrl_valid=1, outs_ready=1 for 7 cycles -> outs sequence 0x11,0x22,0x33,0x11,0x22,0x33,0x11 on back-to-back cycles; outs_last=1 only on the 0x33 tokens.
- Backpressure: outs_ready=0 after the first token -> ctrl_ready=0, outs stays 0x11 for 5 cycles. Raise outs_ready -> next value is 0x22, with no skipped or duplicated entries.
- Restart: after 0x11,0x22, pulse restart together with ctrl_fire -> outs=0x11, then 0x22. Pulse restart alone while idle -> the next token is 0x11.
- Saturate: WRAP=0, 5 tokens -> 0x11,0x22,0x33,0x33,0x33, with outs_last=1 on the last three.
- Reset mid-stream: assert rst=0 while a token is stalled (outs_valid=1, outs_ready=0) -> outs_valid=0 next cycle. The post-reset sequence restarts at 0x11.

Source files
------------

// File: rtl/handshake_constant_table.sv
// Elastic constant source: each accepted control token yields the next entry of a
// compile-time table through a registered, one-slot full-throughput output stage.
module handshake_constant_table #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned NUM_CONSTS = 4,
  parameter logic [NUM_CONSTS*DATA_WIDTH-1:0] CONST_TABLE = '0,
  parameter int unsigned WRAP = 1,
  localparam int unsigned IW = (NUM_CONSTS > 1) ? $clog2(NUM_CONSTS) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  restart,
  input  logic                  ctrl_valid,
  output logic                  ctrl_ready,
  output logic [DATA_WIDTH-1:0] outs,
  output logic                  outs_valid,
  input  logic                  outs_ready,
  output logic                  outs_last,
  output logic [IW-1:0]         outs_idx
);

  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_CONSTS - 1);

  logic [IW-1:0]         idx_q, idx_d;
  logic [DATA_WIDTH-1:0] outs_q, outs_d;
  logic                  outs_valid_q, outs_valid_d;
  logic                  outs_last_q, outs_last_d;
  logic [IW-1:0]         outs_idx_q, outs_idx_d;

  logic                  ctrl_fire;
  logic                  outs_fire;
  logic [IW-1:0]         entry;
  logic [IW-1:0]         next_idx;
  logic [DATA_WIDTH-1:0] entry_value;

  always_comb begin
    ctrl_ready = ~outs_valid_q | outs_ready;
    ctrl_fire  = ctrl_valid & ctrl_ready;
    outs_fire  = outs_valid_q & outs_ready;
    entry      = restart ? '0 : idx_q;

    // Exact compare against the last entry keeps non-power-of-two tables in range.
    if (entry == LAST_IDX) begin
      next_idx = (WRAP != 0) ? '0 : LAST_IDX;
    end else begin
      next_idx = entry + IW'(1);
    end

    entry_value = '0;
    for (int unsigned k = 0; k < NUM_CONSTS; k++) begin
      if (entry == IW'(k)) begin
        entry_value = CONST_TABLE[k*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_comb begin
    idx_d        = idx_q;
    outs_d       = outs_q;
    outs_valid_d = outs_valid_q;
    outs_last_d  = outs_last_q;
    outs_idx_d   = outs_idx_q;

    if (ctrl_fire) begin
      idx_d        = next_idx;
      outs_d       = entry_value;
      outs_idx_d   = entry;
      outs_last_d  = (entry == LAST_IDX);
      outs_valid_d = 1'b1;
    end else begin
      if (restart) begin
        idx_d = '0;
      end
      if (outs_fire) begin
        outs_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      idx_q        <= '0;
      outs_q       <= '0;
      outs_valid_q <= 1'b0;
      outs_last_q  <= 1'b0;
      outs_idx_q   <= '0;
    end else begin
      idx_q        <= idx_d;
      outs_q       <= outs_d;
      outs_valid_q <= outs_valid_d;
      outs_last_q  <= outs_last_d;
      outs_idx_q   <= outs_idx_d;
    end
  end

  assign outs       = outs_q;
  assign outs_valid = outs_valid_q;
  assign outs_last  = outs_last_q;
  assign outs_idx   = outs_idx_q;

endmodule

// File: tb/tb_handshake_constant_table.sv
// Scoreboard bench: a wrapping and a saturating instance share one random/directed
// stimulus stream; a table-walking reference model predicts each emitted token.
module tb_handshake_constant_table;

  localparam int unsigned DW = 8;
  localparam int unsigned NC = 3;
  localparam logic [NC*DW-1:0] TBL_BITS = 24'h332211;

  typedef struct {
    logic [7:0] data;
    logic [1:0] idx;
    logic       last;
  } tok_t;

  logic clk;
  logic rst;
  logic restart;
  logic ctrl_valid;
  logic outs_ready;

  logic       ctrl_ready_w, outs_valid_w, outs_last_w;
  logic [7:0] outs_w;
  logic [1:0] outs_idx_w;
  logic       ctrl_ready_s, outs_valid_s, outs_last_s;
  logic [7:0] outs_s;
  logic [1:0] outs_idx_s;

  handshake_constant_table #(
    .DATA_WIDTH (DW),
    .NUM_CONSTS (NC),
    .CONST_TABLE(TBL_BITS),
    .WRAP       (1)
  ) dut_w (
    .clk       (clk),
    .rst       (rst),
    .restart   (restart),
    .ctrl_valid(ctrl_valid),
    .ctrl_ready(ctrl_ready_w),
    .outs      (outs_w),
    .outs_valid(outs_valid_w),
    .outs_ready(outs_ready),
    .outs_last (outs_last_w),
    .outs_idx  (outs_idx_w)
  );

  handshake_constant_table #(
    .DATA_WIDTH (DW),
    .NUM_CONSTS (NC),
    .CONST_TABLE(TBL_BITS),
    .WRAP       (0)
  ) dut_s (
    .clk       (clk),
    .rst       (rst),
    .restart   (restart),
    .ctrl_valid(ctrl_valid),
    .ctrl_ready(ctrl_ready_s),
    .outs      (outs_s),
    .outs_valid(outs_valid_s),
    .outs_ready(outs_ready),
    .outs_last (outs_last_s),
    .outs_idx  (outs_idx_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state
  logic [7:0] tbl [NC] = '{8'h11, 8'h22, 8'h33};
  tok_t q_w[$];
  tok_t q_s[$];
  int   pos_w = 0;
  int   pos_s = 0;
  bit   was_reset = 1'b1;

  int checks = 0;
  int errors = 0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic tok_t make_tok(input int e);
    tok_t t;
    t.data = tbl[e];
    t.idx  = 2'(e);
    t.last = (e == NC - 1);
    return t;
  endfunction

  // Called after the monitor has retired any token consumed at the coming edge.
  function automatic void model_update();
    int e;
    if (!rst) begin
      q_w.delete();
      q_s.delete();
      pos_w = 0;
      pos_s = 0;
      was_reset = 1'b1;
    end else begin
      was_reset = 1'b0;
      if (ctrl_valid && q_w.size() == 0) begin
        e = restart ? 0 : pos_w;
        q_w.push_back(make_tok(e));
        pos_w = (e + 1) % NC;
        e = restart ? 0 : pos_s;
        q_s.push_back(make_tok(e));
        pos_s = (e + 1 < NC) ? e + 1 : NC - 1;
      end else if (restart) begin
        pos_w = 0;
        pos_s = 0;
      end
    end
  endfunction

  // Monitor: compares against the token currently held, retires it when consumed.
  always @(negedge clk) begin
    chk("w_ctrl_ready", 32'(ctrl_ready_w), 32'((q_w.size() == 0) || outs_ready));
    chk("s_ctrl_ready", 32'(ctrl_ready_s), 32'((q_s.size() == 0) || outs_ready));
    chk("w_outs_valid", 32'(outs_valid_w), 32'(q_w.size() != 0));
    chk("s_outs_valid", 32'(outs_valid_s), 32'(q_s.size() != 0));
    if (was_reset) begin
      chk("w_reset_outs", 32'(outs_w), 32'h0);
      chk("w_reset_idx",  32'(outs_idx_w), 32'h0);
      chk("w_reset_last", 32'(outs_last_w), 32'h0);
      chk("s_reset_outs", 32'(outs_s), 32'h0);
      chk("s_reset_idx",  32'(outs_idx_s), 32'h0);
      chk("s_reset_last", 32'(outs_last_s), 32'h0);
    end
    if (q_w.size() != 0) begin
      if (outs_valid_w) begin
        chk("w_outs",      32'(outs_w),      32'(q_w[0].data));
        chk("w_outs_idx",  32'(outs_idx_w),  32'(q_w[0].idx));
        chk("w_outs_last", 32'(outs_last_w), 32'(q_w[0].last));
      end
      if (outs_ready) void'(q_w.pop_front());
    end
    if (q_s.size() != 0) begin
      if (outs_valid_s) begin
        chk("s_outs",      32'(outs_s),      32'(q_s[0].data));
        chk("s_outs_idx",  32'(outs_idx_s),  32'(q_s[0].idx));
        chk("s_outs_last", 32'(outs_last_s), 32'(q_s[0].last));
      end
      if (outs_ready) void'(q_s.pop_front());
    end
  end

  task automatic step(input logic r, input logic cv, input logic ordy, input logic rs);
    @(posedge clk);
    #2;
    rst        = r;
    ctrl_valid = cv;
    outs_ready = ordy;
    restart    = rs;
    @(negedge clk);
    #1;
    model_update();
  endtask

  task automatic repeat_step(input int n, input logic r, input logic cv,
                             input logic ordy, input logic rs);
    for (int i = 0; i < n; i++) step(r, cv, ordy, rs);
  endtask

  initial begin
    rst        = 1'b0;
    ctrl_valid = 1'b1;
    outs_ready = 1'b1;
    restart    = 1'b0;

    // Reset held with ctrl_valid asserted, then streaming
    repeat_step(3, 1'b0, 1'b1, 1'b1, 1'b0);
    repeat_step(7, 1'b1, 1'b1, 1'b1, 1'b0);

    // Backpressure after the first token
    repeat_step(2, 1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    repeat_step(5, 1'b1, 1'b1, 1'b0, 1'b0);
    repeat_step(3, 1'b1, 1'b1, 1'b1, 1'b0);
    repeat_step(2, 1'b1, 1'b0, 1'b1, 1'b0);

    // Restart with a fire, then restart alone while idle
    step(1'b0, 1'b0, 1'b1, 1'b0);
    repeat_step(2, 1'b1, 1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b1);
    step(1'b1, 1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b0);

    // Reset while a token is stalled
    step(1'b1, 1'b1, 1'b0, 1'b0);
    repeat_step(2, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    repeat_step(4, 1'b1, 1'b1, 1'b1, 1'b0);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      step($urandom_range(0, 39) != 0,
           $urandom_range(0, 3) != 0,
           $urandom_range(0, 2) != 0,
           $urandom_range(0, 7) == 0);
    end

    repeat_step(3, 1'b1, 1'b0, 1'b1, 1'b0);
    @(posedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
